// File: rtl/uart_rx_buffer_if.sv
// rtl/uart_rx_buffer_if.sv - receiver/consumer handshake bundle for uart_rx_buffer
interface uart_rx_buffer_if #(
  parameter int DEPTH_LOG2 = 6
) ();

  logic                  rxDone;
  logic [7:0]            rxData;
  logic                  rxFrameErr;
  logic                  rdReq;
  logic                  clearErr;
  logic [7:0]            dataOut;
  logic                  dataValid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic [7:0]            errCount;
  logic                  almostFull;

  modport master (
    output rxDone, rxData, rxFrameErr, rdReq, clearErr,
    input  dataOut, dataValid, empty, full, count, overflow, errCount, almostFull
  );

  modport slave (
    input  rxDone, rxData, rxFrameErr, rdReq, clearErr,
    output dataOut, dataValid, empty, full, count, overflow, errCount, almostFull
  );

endinterface

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive byte FIFO with framing-error drop and overflow flag
// Optional registered almostFull output enabled by UART_RX_BUFFER_ALMOST_FULL_EN.
module uart_rx_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int AF_MARGIN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_buffer_if.slave  bus
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

  logic [7:0]            mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [7:0]            dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            errc_q, errc_d;

  logic                  good_byte;
  logic                  pop_en;
  logic                  wr_en;
  logic                  ovf_evt;
  logic                  fe_evt;

  always_comb begin
    good_byte = bus.rxDone & ~bus.rxFrameErr;
    fe_evt    = bus.rxDone &  bus.rxFrameErr;
    pop_en    = bus.rdReq & ~empty_q;
    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    wr_en     = good_byte & (~full_q | pop_en);
    ovf_evt   = good_byte & full_q & ~pop_en;
  end

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ovf_d    = ovf_q;
    errc_d   = errc_q;

    if (wr_en) begin
      wp_d = wp_q + PTR_ONE;
    end

    if (pop_en) begin
      rp_d     = rp_q + PTR_ONE;
      dout_d   = mem_q[rp_q];
      dvalid_d = 1'b1;
    end

    if (wr_en && !pop_en) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_en && !wr_en) begin
      count_d = count_q - CNT_ONE;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_MAX);

    if (bus.clearErr) begin
      ovf_d  = 1'b0;
      errc_d = 8'h00;
    end else begin
      if (ovf_evt) begin
        ovf_d = 1'b1;
      end
      if (fe_evt && errc_q != 8'hFF) begin
        errc_d = errc_q + 8'h01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= 8'h00;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      errc_q   <= 8'h00;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      errc_q   <= errc_d;
    end
  end

  // Storage carries no reset; contents are only observable through rp after a write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wp_q] <= bus.rxData;
    end
  end

`ifdef UART_RX_BUFFER_ALMOST_FULL_EN
  localparam logic [DEPTH_LOG2:0] AF_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH - AF_MARGIN);

  logic af_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (count_d >= AF_LEVEL);
    end
  end

  assign bus.almostFull = af_q;
`else
  assign bus.almostFull = (AF_MARGIN < 0);
`endif

  assign bus.dataOut   = dout_q;
  assign bus.dataValid = dvalid_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.errCount  = errc_q;

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte buffer between the UART receiver and the consuming logic. It captures each byte the receiver completes into an internal circular FIFO, drops bytes flagged with a framing error and counts them, and lets the consumer pop bytes with a request/valid handshake. It flags overflow when the receiver delivers a byte while the FIFO is full.

## Interface
- DEPTH_LOG2, 6: FIFO depth is 2^DEPTH_LOG2 bytes (64 by default). Legal range 2..10.
- AF_MARGIN, 4: almost-full threshold margin, used only with UART_RX_BUFFER_ALMOST_FULL_EN. Legal range 1..2^DEPTH_LOG2-1.

- clk  in  1  single clock for all logic; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rxDone  in  1  one-cycle pulse from the receiver: a byte is complete on rxData.
- rxData  in  8  received byte; valid only while rxDone=1.
- rxFrameErr  in  1  qualifies rxDone: the byte had a bad stop bit.
- rdReq  in  1  consumer pop request; level-sampled each cycle.
- dataOut  out  8  popped byte; holds its value between pops.
- dataValid  out  1  one-cycle strobe: dataOut carries a newly popped byte.
- empty  out  1  FIFO holds 0 bytes.
- full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky: at least one byte was lost because the FIFO was full.
- errCount  out  8  saturating count of bytes dropped for framing error.
- clearErr  in  1  clears overflow and errCount.
- almostFull  out  1  occupancy >= 2^DEPTH_LOG2 - AF_MARGIN (see Configuration).

## Operation
- Storage is 2^DEPTH_LOG2 x 8 memory with write pointer wp and read pointer rp, each DEPTH_LOG2 bits wide. Both pointers wrap modulo depth with natural binary rollover. count is a separate register.
- Write: when rxDone=1 and rxFrameErr=0:
  - if not full, or if a pop is accepted in the same cycle: mem[wp] <= rxData and wp increments.
  - otherwise the byte is dropped and overflow <= 1.
- Framing error: when rxDone=1 and rxFrameErr=1, the byte is never stored. errCount increments and saturates at 255.
- Pop: accepted when rdReq=1 and empty=0. On the accepting edge, dataOut <= mem[rp], dataValid <= 1, and rp increments. On any edge without an accepted pop, dataValid <= 0.
- rdReq while empty is ignored. There is no error flag and no change to dataOut.
- count update: +1 on write only, -1 on pop only, unchanged on a simultaneous write and pop.
- Simultaneous write and pop while full: both occur, count stays at maximum, and overflow is not set.
- Simultaneous write and pop while empty: the pop is not accepted; the write occurs.
- clearErr has priority over a same-cycle overflow or errCount event. The clear wins, and that event is not recorded.
- empty, full and almostFull are registered. Each reflects the count value present after the same edge.

## Timing
- Reset values: dataOut=0x00, dataValid=0, empty=1, full=0, count=0, overflow=0, errCount=0, almostFull=0, wp=rp=0. Memory contents are don't-care.
- rst is sampled at an edge and overrides all other inputs on that edge. A reset during traffic discards all stored bytes; a dataValid due on that edge is suppressed.
- Write latency: rxDone at edge N gives count, empty and full updated after edge N. The byte is poppable by an rdReq sampled at edge N+1.
- Pop latency: rdReq accepted at edge N gives dataValid=1 and dataOut valid in the cycle after edge N, for exactly one cycle.
- Holding rdReq high streams one byte per cycle until empty. No bubbles and no duplicate pops.
- Throughput: one write and one pop per cycle, sustained.

## Configuration
- UART_RX_BUFFER_ALMOST_FULL_EN defined: almostFull is a registered output equal to (count >= 2^DEPTH_LOG2 - AF_MARGIN). It is intended to drive RTS deassertion.
- Not defined: no comparator logic; almostFull is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then pulse rxDone with rxData=0x41, 0x42, 0x43 on separate cycles, then hold rdReq for 4 cycles:
  - dataOut is 0x41, 0x42, 0x43 on three consecutive dataValid strobes;
  - no fourth strobe;
  - empty=1 and count=0 at the end.
- Fill 64 bytes (0x00..0x3F), then rxDone with 0x99 and no rdReq:
  - full=1, count=64, overflow=1;
  - popping all bytes yields 0x00..0x3F with 0x99 absent.
- With the FIFO full, assert rxDone(0x77) and rdReq in the same cycle:
  - count stays 64, overflow stays 0;
  - dataOut=0x00;
  - 0x77 is the last byte popped.
- Pulse rxDone with rxFrameErr=1 300 times:
  - errCount saturates at 255, count=0;
  - clearErr pulse returns errCount=0 and overflow=0.
- Write 70 and pop 70 in a staggered pattern spanning a pointer wrap: output order is preserved across the wrap.
- With UART_RX_BUFFER_ALMOST_FULL_EN and AF_MARGIN=4:
  - almostFull rises the cycle after count reaches 60 and falls after count drops to 59;
  - without the macro it stays 0.
